// File: rtl/memory_arbiter.sv
// ============================================================================
// memory_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter that shares the single RAM port between the instruction
// and data requesters of CPUS cores. One owner is latched per transaction and
// held until the RAM reports ACCESS, so an access in flight is never
// retargeted. Data requests beat instruction requests; inside each class the
// grant rotates fairly using a per-class pointer.
//
// Optional feature macro: MEMORY_ARBITER_WATCHDOG_EN
//   When defined, a BUSY-cycle watchdog aborts a transaction that has not seen
//   ACCESS after TIMEOUT cycles and pulses arb_err for one cycle. When
//   undefined, arb_err is constant 0 and BUSY lasts until ACCESS or abort.
//
// Parameters:
//   CPUS     number of cores (>= 2, power of two)
//   TIMEOUT  BUSY-cycle limit of the watchdog (macro builds only)
//
// Ports:
//   CLK       clock, rising edge
//   RST       synchronous active-high reset
//   iREN      [CPUS]     instruction read request per core
//   dREN      [CPUS]     data read request per core
//   dWEN      [CPUS]     data write request per core
//   iaddr     [CPUS*32]  instruction address per core (lane c = bits c*32+:32)
//   daddr     [CPUS*32]  data address per core
//   dstore    [CPUS*32]  store data per core
//   iwait     [CPUS]     instruction wait, low one cycle on completion
//   dwait     [CPUS]     data wait, low one cycle on completion
//   iload     [CPUS*32]  every lane carries ramload
//   dload     [CPUS*32]  every lane carries ramload
//   ramREN    RAM read strobe
//   ramWEN    RAM write strobe
//   ramaddr   [32] RAM address
//   ramstore  [32] RAM write data
//   ramstate  [2]  RAM status, ramstate_t encoding FREE=0 BUSY=1 ACCESS=2 ERROR=3
//   ramload   [32] RAM read data
//   arb_err   one-cycle watchdog abort pulse
// ============================================================================
module memory_arbiter #(
    parameter int CPUS    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*32-1:0]   iaddr,
    input  logic [CPUS*32-1:0]   daddr,
    input  logic [CPUS*32-1:0]   dstore,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*32-1:0]   iload,
    output logic [CPUS*32-1:0]   dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [1:0]           ramstate,
    input  logic [31:0]          ramload,
    output logic                 arb_err
);

    localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;

    // ramstate_t value that completes a transaction
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic             cls_d_q, cls_d_d;     // 1: data owner, 0: instruction owner
    logic             wr_q,    wr_d;
    logic [PW-1:0]    dptr_q,  dptr_d;
    logic [PW-1:0]    iptr_q,  iptr_d;

`ifdef MEMORY_ARBITER_WATCHDOG_EN
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             arb_err_q, arb_err_d;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    logic [CPUS-1:0]  d_req;
    logic [31:0]      own_iaddr;
    logic [31:0]      own_daddr;
    logic [31:0]      own_dstore;
    logic             own_req;
    logic             busy;

    assign d_req = dREN | dWEN;

    // First set bit at or above ptr, wrapping; CPUS is a power of two so the
    // PW-bit addition wraps modulo CPUS by itself.
    function automatic logic [PW-1:0] rr_pick(input logic [CPUS-1:0] req,
                                              input logic [PW-1:0]   ptr);
        logic [PW-1:0] idx;
        logic [PW-1:0] pick;
        pick = ptr;
        for (int k = CPUS - 1; k >= 0; k--) begin
            idx = ptr + PW'(k);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    // Owner lane selection from the live request inputs
    always_comb begin
        own_iaddr  = '0;
        own_daddr  = '0;
        own_dstore = '0;
        for (int c = 0; c < CPUS; c++) begin
            if (owner_q == PW'(c)) begin
                own_iaddr  = iaddr[c*32 +: 32];
                own_daddr  = daddr[c*32 +: 32];
                own_dstore = dstore[c*32 +: 32];
            end
        end
    end

    // The request bit that was latched at grant time; dropping it aborts.
    assign own_req = cls_d_q ? (wr_q ? dWEN[owner_q] : dREN[owner_q])
                             : iREN[owner_q];

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cls_d_d = cls_d_q;
        wr_d    = wr_q;
        dptr_d  = dptr_q;
        iptr_d  = iptr_q;
`ifdef MEMORY_ARBITER_WATCHDOG_EN
        wd_d      = wd_q;
        arb_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef MEMORY_ARBITER_WATCHDOG_EN
                wd_d = '0;
`endif
                if (|d_req) begin
                    owner_d = rr_pick(d_req, dptr_q);
                    cls_d_d = 1'b1;
                    wr_d    = dWEN[owner_d];
                    state_d = ST_BUSY;
                end else if (|iREN) begin
                    owner_d = rr_pick(iREN, iptr_q);
                    cls_d_d = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (ramstate == RAM_ACCESS) begin
                    state_d = ST_IDLE;
                    if (cls_d_q) dptr_d = owner_q + PW'(1);
                    else         iptr_d = owner_q + PW'(1);
                end else if (!own_req) begin
                    state_d = ST_IDLE;
`ifdef MEMORY_ARBITER_WATCHDOG_EN
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    // Give up on this owner and move its class past it so a
                    // stuck requester cannot starve the others.
                    state_d   = ST_IDLE;
                    arb_err_d = 1'b1;
                    if (cls_d_q) dptr_d = owner_q + PW'(1);
                    else         iptr_d = owner_q + PW'(1);
                end else begin
                    wd_d = wd_q + WD_W'(1);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; owner/class/write flag are only meaningful in BUSY
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            dptr_q  <= '0;
            iptr_q  <= '0;
`ifdef MEMORY_ARBITER_WATCHDOG_EN
            wd_q      <= '0;
            arb_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dptr_q  <= dptr_d;
            iptr_q  <= iptr_d;
`ifdef MEMORY_ARBITER_WATCHDOG_EN
            wd_q      <= wd_d;
            arb_err_q <= arb_err_d;
`endif
        end
        owner_q <= owner_d;
        cls_d_q <= cls_d_d;
        wr_q    <= wr_d;
    end

    // Outputs are forced idle during a reset cycle so a dropped transaction
    // never shows a strobe or wait pulse while RST is high.
    assign busy = (state_q == ST_BUSY) && !RST;

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        if (busy) begin
            ramWEN   = wr_q;
            ramREN   = !wr_q;
            ramaddr  = cls_d_q ? own_daddr : own_iaddr;
            ramstore = wr_q ? own_dstore : 32'd0;
            if (ramstate == RAM_ACCESS) begin
                if (cls_d_q) dwait[owner_q] = 1'b0;
                else         iwait[owner_q] = 1'b0;
            end
        end
    end

    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

`ifdef MEMORY_ARBITER_WATCHDOG_EN
    assign arb_err = arb_err_q && !RST;
`else
    assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

    localparam int CPUS = 2;
    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic              CLK = 1'b0;
    logic              RST;
    logic [CPUS-1:0]   iREN, dREN, dWEN;
    logic [CPUS*32-1:0] iaddr, daddr, dstore;
    logic [CPUS-1:0]   iwait, dwait;
    logic [CPUS*32-1:0] iload, dload;
    logic              ramREN, ramWEN;
    logic [31:0]       ramaddr, ramstore;
    logic [1:0]        ramstate;
    logic [31:0]       ramload;
    logic              arb_err;

    int checks   = 0;
    int failures = 0;

    // RAM model: ACCESS arrives in the lat-th strobed cycle unless hang is set
    int lat     = 1;
    bit hang    = 1'b0;
    int ram_cnt = 0;

    // Reference state: round-robin pointers per class
    int m_dptr = 0;
    int m_iptr = 0;
    int dpulse [CPUS];

    memory_arbiter #(.CPUS(CPUS), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramstate(ramstate), .ramload(ramload), .arb_err(arb_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RST || !(ramREN || ramWEN)) ram_cnt <= 0;
        else                            ram_cnt <= ram_cnt + 1;
    end

    assign ramstate = !(ramREN || ramWEN)            ? S_FREE :
                      (!hang && ram_cnt == lat - 1)  ? S_ACCESS : S_BUSY;

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Winner of a rotation starting at ptr: first requester at ptr, ptr+1, ...
    function automatic int rr(input logic [CPUS-1:0] req, input int ptr);
        for (int k = 0; k < CPUS; k++)
            if (req[(ptr + k) % CPUS]) return (ptr + k) % CPUS;
        return -1;
    endfunction

    task automatic idle_checks();
        chk("idle_ramREN",   {31'd0, ramREN},   32'd0);
        chk("idle_ramWEN",   {31'd0, ramWEN},   32'd0);
        chk("idle_ramaddr",  ramaddr,           32'd0);
        chk("idle_ramstore", ramstore,          32'd0);
        chk("idle_iwait",    {30'd0, iwait},    32'd3);
        chk("idle_dwait",    {30'd0, dwait},    32'd3);
        chk("idle_arb_err",  {31'd0, arb_err},  32'd0);
    endtask

    task automatic busy_checks(input logic [31:0] ea, input logic [31:0] es, input bit w,
                               input logic [1:0] eiw, input logic [1:0] edw);
        chk("busy_ramREN",   {31'd0, ramREN},   {31'd0, !w});
        chk("busy_ramWEN",   {31'd0, ramWEN},   {31'd0, w});
        chk("busy_ramaddr",  ramaddr,           ea);
        chk("busy_ramstore", ramstore,          es);
        chk("busy_iwait",    {30'd0, iwait},    {30'd0, eiw});
        chk("busy_dwait",    {30'd0, dwait},    {30'd0, edw});
        chk("busy_arb_err",  {31'd0, arb_err},  32'd0);
        chk("iload_lane0",   iload[31:0],       ramload);
        chk("dload_lane1",   dload[63:32],      ramload);
    endtask

    task automatic drop_owner(input int o, input bit c);
        if (c) begin
            dREN[o] = 1'b0;
            dWEN[o] = 1'b0;
        end else begin
            iREN[o] = 1'b0;
        end
    endtask

    // Called at a negedge in IDLE with requests already driven; the next
    // posedge is the grant edge. Returns at a negedge in IDLE.
    // mode 0: keep requests, 1: owner drops after ACCESS, 2: owner aborts.
    task automatic run_txn(input int o, input bit c, input bit w, input int L, input int mode);
        logic [31:0] ea, es;
        logic [1:0]  eiw, edw;
        ea   = c ? daddr[o*32 +: 32] : iaddr[o*32 +: 32];
        es   = w ? dstore[o*32 +: 32] : 32'd0;
        lat  = L;
        hang = (mode == 2);
        @(posedge CLK);
        if (mode == 2) begin
            @(negedge CLK);
            busy_checks(ea, es, w, 2'b11, 2'b11);
            @(posedge CLK); #1;
            drop_owner(o, c);
            @(negedge CLK);
            busy_checks(ea, es, w, 2'b11, 2'b11);
            @(negedge CLK);
            idle_checks();
            hang = 1'b0;
        end else begin
            for (int k = 1; k <= L; k++) begin
                @(negedge CLK);
                eiw = 2'b11;
                edw = 2'b11;
                if (k == L) begin
                    if (c) edw[o] = 1'b0;
                    else   eiw[o] = 1'b0;
                end
                busy_checks(ea, es, w, eiw, edw);
                for (int b = 0; b < CPUS; b++)
                    if (dwait[b] === 1'b0) dpulse[b]++;
            end
            @(posedge CLK); #1;
            if (mode == 1) drop_owner(o, c);
            if (c) m_dptr = (o + 1) % CPUS;
            else   m_iptr = (o + 1) % CPUS;
            @(negedge CLK);
            idle_checks();
        end
    endtask

    // Predict the owner from the currently driven requests and run one round
    task automatic step(input bit abort, input bit drop, input int L);
        logic [CPUS-1:0] dq;
        int o;
        bit c, w;
        dq = dREN | dWEN;
        if (dq != '0) begin
            o = rr(dq, m_dptr); c = 1'b1; w = dWEN[o];
        end else if (iREN != '0) begin
            o = rr(iREN, m_iptr); c = 1'b0; w = 1'b0;
        end else begin
            @(posedge CLK);
            @(negedge CLK);
            idle_checks();
            return;
        end
        run_txn(o, c, w, L, abort ? 2 : (drop ? 1 : 0));
    endtask

    initial begin
        int o;
        RST     = 1'b1;
        iREN    = '0;
        dREN    = '0;
        dWEN    = '0;
        iaddr   = {32'h0000_2004, 32'h0000_1000};
        daddr   = {32'h0000_8004, 32'h0000_4000};
        dstore  = {32'h1111_2222, 32'h3333_4444};
        ramload = $urandom;
        for (int b = 0; b < CPUS; b++) dpulse[b] = 0;

        // Reset state (outputs forced idle while RST is high)
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        idle_checks();
        RST = 1'b0;
        @(negedge CLK);
        idle_checks();

        // Abort: core0 instruction request drops before ACCESS
        iREN = 2'b01;
        step(1'b1, 1'b0, 1);
        // iptr must still be 0: with both cores requesting, core0 wins
        iREN = 2'b11;
        step(1'b0, 1'b1, 1);
        iREN = '0;

        // Data priority over instruction, RAM latency 2
        iREN = 2'b01;
        dREN = 2'b10;
        step(1'b0, 1'b1, 2);
        step(1'b0, 1'b1, 2);

        // Write path on core1
        daddr[63:32]  = 32'h0000_0100;
        dstore[63:32] = 32'hDEAD_BEEF;
        dWEN = 2'b10;
        step(1'b0, 1'b1, 3);

        // Fairness: both cores hold dREN for four transactions
        for (int b = 0; b < CPUS; b++) dpulse[b] = 0;
        dREN = 2'b11;
        for (int t = 0; t < 4; t++) step(1'b0, 1'b0, 1 + t % 2);
        dREN = '0;
        chk("fair_dwait0_pulses", dpulse[0], 32'd2);
        chk("fair_dwait1_pulses", dpulse[1], 32'd2);

        // Randomized rounds against the reference model
        for (int r = 0; r < 30; r++) begin
            if (($urandom % 2) == 0 || (iREN | dREN | dWEN) == '0) begin
                iREN   = CPUS'($urandom);
                dREN   = CPUS'($urandom) & CPUS'($urandom);
                dWEN   = CPUS'($urandom) & CPUS'($urandom);
                iaddr  = {$urandom, $urandom};
                daddr  = {$urandom, $urandom};
                dstore = {$urandom, $urandom};
            end
            step(($urandom % 5) == 0, 1'b1, $urandom_range(1, 4));
        end
        iREN = '0;
        dREN = '0;
        dWEN = '0;
        @(negedge CLK);
        idle_checks();

        // Reset mid-transaction; first move dptr to 1
        dREN = 2'b01;
        step(1'b0, 1'b1, 1);
        dWEN = 2'b01;
        hang = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_pre_ramWEN", {31'd0, ramWEN}, 32'd1);
        RST = 1'b1;
        #1;
        chk("rst_cycle_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("rst_cycle_dwait",  {30'd0, dwait},  32'd3);
        @(posedge CLK); #1;
        RST  = 1'b0;
        dWEN = '0;
        hang = 1'b0;
        m_dptr = 0;
        m_iptr = 0;
        @(negedge CLK);
        idle_checks();
        // dptr back at 0: with both cores requesting, core0 wins
        dREN = 2'b11;
        step(1'b0, 1'b1, 1);
        dREN = '0;

`ifdef MEMORY_ARBITER_WATCHDOG_EN
        // Watchdog: RAM never answers, TIMEOUT=4
        dREN = 2'b11;
        hang = 1'b1;
        o = rr(2'b11, m_dptr);
        @(posedge CLK);
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            busy_checks(daddr[o*32 +: 32], 32'd0, 1'b0, 2'b11, 2'b11);
        end
        @(negedge CLK);
        chk("wd_arb_err",  {31'd0, arb_err}, 32'd1);
        chk("wd_ramREN",   {31'd0, ramREN},  32'd0);
        chk("wd_dwait",    {30'd0, dwait},   32'd3);
        m_dptr = (o + 1) % CPUS;
        o = rr(2'b11, m_dptr);
        @(negedge CLK);
        busy_checks(daddr[o*32 +: 32], 32'd0, 1'b0, 2'b11, 2'b11);
        @(posedge CLK); #1;
        dREN = '0;
        @(negedge CLK);
        @(negedge CLK);
        idle_checks();
        hang = 1'b0;
`else
        o = 0;
        chk("arb_err_tied", {31'd0, arb_err}, 32'(o));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
